// File: rtl/decode_if.sv
// Decode-to-execute output slot: valid/ready handshake plus the decoded fields.
//   master (decode)  : drives output_valid_o and every decoded field, samples output_ready_i
//   slave  (execute) : samples the slot, drives output_ready_i
interface decode_if;
  logic        output_valid_o;
  logic        output_ready_i;
  logic [31:0] pc_o;
  logic [31:0] alu_operand1_o;
  logic [31:0] alu_operand2_o;
  logic [2:0]  alu_op_o;
  logic        alu_alt_o;
  logic [31:0] rs1_value_o;
  logic [31:0] rs2_value_o;
  logic [1:0]  branch_type_o;
  logic [2:0]  branch_cond_o;
  logic [31:0] branch_offset_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [2:0]  mem_size_o;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic        illegal_o;

  modport master (
    output output_valid_o, pc_o, alu_operand1_o, alu_operand2_o, alu_op_o, alu_alt_o,
           rs1_value_o, rs2_value_o, branch_type_o, branch_cond_o, branch_offset_o,
           mem_read_o, mem_write_o, mem_size_o, reg_write_o, reg_addr_o, illegal_o,
    input  output_ready_i
  );

  modport slave (
    input  output_valid_o, pc_o, alu_operand1_o, alu_operand2_o, alu_op_o, alu_alt_o,
           rs1_value_o, rs2_value_o, branch_type_o, branch_cond_o, branch_offset_o,
           mem_read_o, mem_write_o, mem_size_o, reg_write_o, reg_addr_o, illegal_o,
    output output_ready_i
  );
endinterface

// File: rtl/decode.sv
// RV32I decode stage: reads the register file, builds ALU operands, immediates and
// control fields, and registers them into a single valid/ready output slot.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   input_valid_i/input_ready_o  fetch handshake; instr_i, pc_i carry the instruction
//   flush_i                      drop the slot and any incoming instruction
//   raddr*_o / rdata*_i          register file read ports (combinational read)
//   wb_write_i/wb_addr_i/wb_data_i  writeback port, used only for bypass
//   out_if                       decoded output slot (decode_if.master)
// Build option: define DECODE_BYPASS_EN to forward same-cycle writeback data around
// the register file; otherwise the wb_* inputs are ignored.
module decode (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [4:0]  raddr1_o,
  input  logic [31:0] rdata1_i,
  output logic [4:0]  raddr2_o,
  input  logic [31:0] rdata2_i,
  input  logic        wb_write_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  decode_if.master    out_if
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic        accept;

  logic [31:0] op1_d, op2_d, boff_d;
  logic [2:0]  alu_op_d, bcond_d, msize_d;
  logic        alt_d, mr_d, mw_d, rw_d, ill_d;
  logic [1:0]  btype_d;
  logic [4:0]  raddr_d;

  logic        valid_q;
  logic [31:0] pc_q, op1_q, op2_q, rs1v_q, rs2v_q, boff_q;
  logic [2:0]  alu_op_q, bcond_q, msize_q;
  logic        alt_q, mr_q, mw_q, rw_q, ill_q;
  logic [1:0]  btype_q;
  logic [4:0]  raddr_q;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign rd       = instr_i[11:7];
  assign raddr1_o = instr_i[19:15];
  assign raddr2_o = instr_i[24:20];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

`ifdef DECODE_BYPASS_EN
  // Writeback to the same register this cycle has not reached the regfile yet.
  assign rs1_val = (wb_write_i && (wb_addr_i != 5'd0) && (wb_addr_i == raddr1_o)) ? wb_data_i : rdata1_i;
  assign rs2_val = (wb_write_i && (wb_addr_i != 5'd0) && (wb_addr_i == raddr2_o)) ? wb_data_i : rdata2_i;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_write_i, wb_addr_i, wb_data_i};
  assign rs1_val   = rdata1_i;
  assign rs2_val   = rdata2_i;
`endif

  assign input_ready_o = ~valid_q | out_if.output_ready_i;
  assign accept        = input_valid_i & input_ready_o & ~flush_i;

  // Per-opcode field decode.
  always_comb begin
    op1_d    = '0;
    op2_d    = '0;
    alu_op_d = 3'b000;
    alt_d    = 1'b0;
    btype_d  = 2'b00;
    bcond_d  = 3'b000;
    boff_d   = '0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    msize_d  = 3'b000;
    rw_d     = 1'b0;
    ill_d    = 1'b0;
    case (opcode)
      OP_LUI: begin
        op2_d = imm_u;
        rw_d  = 1'b1;
      end
      OP_AUIPC: begin
        op1_d = pc_i;
        op2_d = imm_u;
        rw_d  = 1'b1;
      end
      OP_JAL: begin
        op1_d   = pc_i;
        op2_d   = 32'd4;
        rw_d    = 1'b1;
        btype_d = 2'b01;
        boff_d  = imm_j;
      end
      OP_JALR: begin
        op1_d   = pc_i;
        op2_d   = 32'd4;
        rw_d    = 1'b1;
        btype_d = 2'b10;
        boff_d  = imm_i;
      end
      OP_BRANCH: begin
        op1_d   = rs1_val;
        op2_d   = rs2_val;
        btype_d = 2'b11;
        bcond_d = funct3;
        boff_d  = imm_b;
      end
      OP_LOAD: begin
        op1_d   = rs1_val;
        op2_d   = imm_i;
        mr_d    = 1'b1;
        msize_d = funct3;
        rw_d    = 1'b1;
      end
      OP_STORE: begin
        op1_d   = rs1_val;
        op2_d   = imm_s;
        mw_d    = 1'b1;
        msize_d = funct3;
      end
      OP_IMM: begin
        op1_d    = rs1_val;
        op2_d    = imm_i;
        alu_op_d = funct3;
        // Only SRAI uses bit 30 as a mode bit; elsewhere it is immediate data.
        alt_d    = (funct3 == 3'b101) ? instr_i[30] : 1'b0;
        rw_d     = 1'b1;
      end
      OP_OP: begin
        op1_d    = rs1_val;
        op2_d    = rs2_val;
        alu_op_d = funct3;
        alt_d    = instr_i[30];
        rw_d     = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
    raddr_d = rw_d ? rd : 5'd0;
  end

  // Output slot: flush beats accept; consumed slot empties when nothing new arrives.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rs1v_q   <= '0;
      rs2v_q   <= '0;
      alu_op_q <= '0;
      alt_q    <= 1'b0;
      btype_q  <= '0;
      bcond_q  <= '0;
      boff_q   <= '0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      msize_q  <= '0;
      rw_q     <= 1'b0;
      raddr_q  <= '0;
      ill_q    <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      pc_q     <= pc_i;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rs1v_q   <= rs1_val;
      rs2v_q   <= rs2_val;
      alu_op_q <= alu_op_d;
      alt_q    <= alt_d;
      btype_q  <= btype_d;
      bcond_q  <= bcond_d;
      boff_q   <= boff_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      msize_q  <= msize_d;
      rw_q     <= rw_d;
      raddr_q  <= raddr_d;
      ill_q    <= ill_d;
    end else if (out_if.output_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_if.output_valid_o  = valid_q;
  assign out_if.pc_o            = pc_q;
  assign out_if.alu_operand1_o  = op1_q;
  assign out_if.alu_operand2_o  = op2_q;
  assign out_if.alu_op_o        = alu_op_q;
  assign out_if.alu_alt_o       = alt_q;
  assign out_if.rs1_value_o     = rs1v_q;
  assign out_if.rs2_value_o     = rs2v_q;
  assign out_if.branch_type_o   = btype_q;
  assign out_if.branch_cond_o   = bcond_q;
  assign out_if.branch_offset_o = boff_q;
  assign out_if.mem_read_o      = mr_q;
  assign out_if.mem_write_o     = mw_q;
  assign out_if.mem_size_o      = msize_q;
  assign out_if.reg_write_o     = rw_q;
  assign out_if.reg_addr_o      = raddr_q;
  assign out_if.illegal_o       = ill_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: a table of single-instruction vectors plus hand-written
// reset, stall, flush, drain and writeback-bypass sequences.
module tb_decode;

`ifdef DECODE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        input_valid_i;
  logic        input_ready_o;
  logic [31:0] instr_i, pc_i;
  logic        flush_i;
  logic [4:0]  raddr1_o, raddr2_o;
  logic [31:0] rdata1_i, rdata2_i;
  logic        wb_write_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;

  decode_if out_if ();

  decode dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .input_valid_i (input_valid_i),
    .input_ready_o (input_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .raddr1_o      (raddr1_o),
    .rdata1_i      (rdata1_i),
    .raddr2_o      (raddr2_o),
    .rdata2_i      (rdata2_i),
    .wb_write_i    (wb_write_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .out_if        (out_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr, pc, rd1, rd2, op1, op2, boff;
    logic [2:0]  alu_op, bcond, msize;
    logic        alt, mr, mw, rw, ill;
    logic [1:0]  btype;
    logic [4:0]  raddr;
    logic [4:0]  chk;  // [0] alu op/alt [1] operands [2] offset [3] mem size [4] cond
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] instr, pc, rd1, rd2, op1, op2,
                              input logic [2:0] alu_op, input logic alt,
                              input logic [1:0] btype, input logic [2:0] bcond,
                              input logic [31:0] boff, input logic mr, mw,
                              input logic [2:0] msize, input logic rw,
                              input logic [4:0] raddr, input logic ill,
                              input logic [4:0] c);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.op1 = op1; v.op2 = op2;
    v.alu_op = alu_op; v.alt = alt; v.btype = btype; v.bcond = bcond; v.boff = boff;
    v.mr = mr; v.mw = mw; v.msize = msize; v.rw = rw; v.raddr = raddr; v.ill = ill;
    v.chk = c;
    return v;
  endfunction

  initial begin
    logic [31:0] w;
    //             instr         pc          rd1           rd2           op1           op2          alu  alt bt    bc    boff         mr mw ms rw rd ill chk
    vecs[0]  = mk(32'hFFD08293, 32'h000, 32'd10,       32'h99,       32'd10,       32'hFFFFFFFD, 3'd0, 0, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 1, 5'd5,  0, 5'b00011); // addi x5,x1,-3
    vecs[1]  = mk(32'hFE208CE3, 32'h040, 32'd5,        32'd5,        32'd5,        32'd5,        3'd0, 0, 2'd3, 3'd0, 32'hFFFFFFF8, 0, 0, 3'd0, 0, 5'd0,  0, 5'b10110); // beq -8
    vecs[2]  = mk(32'h123451B7, 32'h044, 32'hAAAA,     32'hBBBB,     32'h0,        32'h12345000, 3'd0, 0, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 1, 5'd3,  0, 5'b00011); // lui
    vecs[3]  = mk(32'h80000217, 32'h100, 32'h1,        32'h2,        32'h100,      32'h80000000, 3'd0, 0, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 1, 5'd4,  0, 5'b00011); // auipc
    vecs[4]  = mk(32'h010000EF, 32'h200, 32'h3,        32'h4,        32'h200,      32'd4,        3'd0, 0, 2'd1, 3'd0, 32'h10,      0, 0, 3'd0, 1, 5'd1,  0, 5'b00111); // jal +16
    vecs[5]  = mk(32'hFFC28167, 32'h300, 32'h1000,     32'h5,        32'h300,      32'd4,        3'd0, 0, 2'd2, 3'd0, 32'hFFFFFFFC, 0, 0, 3'd0, 1, 5'd2,  0, 5'b00111); // jalr -4
    vecs[6]  = mk(32'h00812303, 32'h304, 32'h2000,     32'h6,        32'h2000,     32'd8,        3'd0, 0, 2'd0, 3'd0, 32'h0,       1, 0, 3'd2, 1, 5'd6,  0, 5'b01011); // lw
    vecs[7]  = mk(32'hFE71AA23, 32'h308, 32'h3000,     32'hDEADBEEF, 32'h3000,     32'hFFFFFFF4, 3'd0, 0, 2'd0, 3'd0, 32'h0,       0, 1, 3'd2, 0, 5'd0,  0, 5'b01011); // sw -12
    vecs[8]  = mk(32'h4034D413, 32'h30C, 32'h80000000, 32'h7,        32'h80000000, 32'h403,      3'd5, 1, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 1, 5'd8,  0, 5'b00011); // srai
    vecs[9]  = mk(32'h40000093, 32'h310, 32'h0,        32'h8,        32'h0,        32'h400,      3'd0, 0, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 1, 5'd1,  0, 5'b00011); // addi imm bit30
    vecs[10] = mk(32'h40C58533, 32'h314, 32'd20,       32'd7,        32'd20,       32'd7,        3'd0, 1, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 1, 5'd10, 0, 5'b00011); // sub
    vecs[11] = mk(32'h0000007F, 32'h318, 32'h9,        32'hA,        32'h0,        32'h0,        3'd0, 0, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 0, 5'd0,  1, 5'b00000); // illegal
    vecs[12] = mk(32'h00100013, 32'h31C, 32'h0,        32'hB,        32'h0,        32'd1,        3'd0, 0, 2'd0, 3'd0, 32'h0,       0, 0, 3'd0, 1, 5'd0,  0, 5'b00011); // addi x0
    vecs[13] = mk(32'h00209463, 32'h320, 32'h1,        32'h2,        32'h1,        32'h2,        3'd0, 0, 2'd3, 3'd1, 32'h8,       0, 0, 3'd0, 0, 5'd0,  0, 5'b10110); // bne +8

    rst_i = 1'b0; input_valid_i = 1'b1; instr_i = vecs[0].instr; pc_i = 32'h44;
    flush_i = 1'b0; rdata1_i = 32'd10; rdata2_i = 32'd0;
    wb_write_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    out_if.output_ready_i = 1'b0;

    // Reset held two edges with a valid instruction presented.
    step(); step();
    chk("rst_valid", 32'(out_if.output_valid_o), 32'd0);
    chk("rst_ready", 32'(input_ready_o), 32'd1);
    chk("rst_op1", out_if.alu_operand1_o, 32'd0);
    chk("rst_pc", out_if.pc_o, 32'd0);
    chk("rst_ctrl", 32'({out_if.reg_write_o, out_if.reg_addr_o, out_if.mem_read_o,
                         out_if.mem_write_o, out_if.branch_type_o, out_if.illegal_o,
                         out_if.alu_op_o}), 32'd0);

    rst_i = 1'b1;
    out_if.output_ready_i = 1'b1;
    foreach (vecs[i]) begin
      instr_i = vecs[i].instr; pc_i = vecs[i].pc;
      rdata1_i = vecs[i].rd1; rdata2_i = vecs[i].rd2; input_valid_i = 1'b1;
      #1;
      w = vecs[i].instr;
      chk($sformatf("v%0d raddr1", i), 32'(raddr1_o), 32'(w[19:15]));
      chk($sformatf("v%0d raddr2", i), 32'(raddr2_o), 32'(w[24:20]));
      step();
      chk($sformatf("v%0d valid", i), 32'(out_if.output_valid_o), 32'd1);
      chk($sformatf("v%0d pc", i), out_if.pc_o, vecs[i].pc);
      chk($sformatf("v%0d rs1v", i), out_if.rs1_value_o, vecs[i].rd1);
      chk($sformatf("v%0d rs2v", i), out_if.rs2_value_o, vecs[i].rd2);
      chk($sformatf("v%0d btype", i), 32'(out_if.branch_type_o), 32'(vecs[i].btype));
      chk($sformatf("v%0d mem_rd", i), 32'(out_if.mem_read_o), 32'(vecs[i].mr));
      chk($sformatf("v%0d mem_wr", i), 32'(out_if.mem_write_o), 32'(vecs[i].mw));
      chk($sformatf("v%0d reg_wr", i), 32'(out_if.reg_write_o), 32'(vecs[i].rw));
      chk($sformatf("v%0d reg_addr", i), 32'(out_if.reg_addr_o), 32'(vecs[i].raddr));
      chk($sformatf("v%0d illegal", i), 32'(out_if.illegal_o), 32'(vecs[i].ill));
      if (vecs[i].chk[0]) begin
        chk($sformatf("v%0d alu_op", i), 32'(out_if.alu_op_o), 32'(vecs[i].alu_op));
        chk($sformatf("v%0d alu_alt", i), 32'(out_if.alu_alt_o), 32'(vecs[i].alt));
      end
      if (vecs[i].chk[1]) begin
        chk($sformatf("v%0d op1", i), out_if.alu_operand1_o, vecs[i].op1);
        chk($sformatf("v%0d op2", i), out_if.alu_operand2_o, vecs[i].op2);
      end
      if (vecs[i].chk[2]) chk($sformatf("v%0d boff", i), out_if.branch_offset_o, vecs[i].boff);
      if (vecs[i].chk[3]) chk($sformatf("v%0d msize", i), 32'(out_if.mem_size_o), 32'(vecs[i].msize));
      if (vecs[i].chk[4]) chk($sformatf("v%0d bcond", i), 32'(out_if.branch_cond_o), 32'(vecs[i].bcond));
    end

    // Drain: nothing new, consumer ready -> slot empties.
    input_valid_i = 1'b0;
    step();
    chk("drain_valid", 32'(out_if.output_valid_o), 32'd0);
    chk("drain_ready", 32'(input_ready_o), 32'd1);

    // Stall: slot holds ADDI while LUI waits.
    instr_i = vecs[0].instr; pc_i = 32'h500; rdata1_i = 32'd10; rdata2_i = 32'h99;
    input_valid_i = 1'b1;
    step();
    out_if.output_ready_i = 1'b0;
    instr_i = vecs[2].instr; pc_i = 32'h504; rdata1_i = 32'hAAAA; rdata2_i = 32'hBBBB;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d ready", c), 32'(input_ready_o), 32'd0);
      step();
      chk($sformatf("stall%0d valid", c), 32'(out_if.output_valid_o), 32'd1);
      chk($sformatf("stall%0d op1", c), out_if.alu_operand1_o, 32'd10);
      chk($sformatf("stall%0d op2", c), out_if.alu_operand2_o, 32'hFFFFFFFD);
      chk($sformatf("stall%0d raddr", c), 32'(out_if.reg_addr_o), 32'd5);
      chk($sformatf("stall%0d pc", c), out_if.pc_o, 32'h500);
    end
    out_if.output_ready_i = 1'b1;
    #1;
    chk("unstall_ready", 32'(input_ready_o), 32'd1);
    step();
    chk("unstall_valid", 32'(out_if.output_valid_o), 32'd1);
    chk("unstall_op2", out_if.alu_operand2_o, 32'h12345000);
    chk("unstall_raddr", 32'(out_if.reg_addr_o), 32'd3);
    chk("unstall_pc", out_if.pc_o, 32'h504);

    // Flush with a valid slot, a stalled consumer and a new instruction offered.
    out_if.output_ready_i = 1'b0;
    flush_i = 1'b1; input_valid_i = 1'b1;
    instr_i = vecs[10].instr; pc_i = 32'h600; rdata1_i = 32'd20; rdata2_i = 32'd7;
    step();
    chk("flush_valid", 32'(out_if.output_valid_o), 32'd0);
    flush_i = 1'b0; input_valid_i = 1'b0;
    step();
    chk("postflush_valid", 32'(out_if.output_valid_o), 32'd0);
    chk("postflush_ready", 32'(input_ready_o), 32'd1);

    // Writeback bypass: add x5,x1,x2.
    out_if.output_ready_i = 1'b1; input_valid_i = 1'b1;
    instr_i = 32'h002082B3; pc_i = 32'h700; rdata1_i = 32'd0; rdata2_i = 32'd7;
    wb_write_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'h55;
    step();
    chk("byp1_op1", out_if.alu_operand1_o, BYP ? 32'h55 : 32'd0);
    chk("byp1_rs1v", out_if.rs1_value_o, BYP ? 32'h55 : 32'd0);
    chk("byp1_op2", out_if.alu_operand2_o, 32'd7);
    wb_addr_i = 5'd0; rdata1_i = 32'h11;
    step();
    chk("byp_x0_op1", out_if.alu_operand1_o, 32'h11);
    wb_addr_i = 5'd2;
    step();
    chk("byp2_op2", out_if.alu_operand2_o, BYP ? 32'h55 : 32'd7);
    chk("byp2_rs2v", out_if.rs2_value_o, BYP ? 32'h55 : 32'd7);
    chk("byp2_op1", out_if.alu_operand1_o, 32'h11);
    wb_write_i = 1'b0; wb_addr_i = 5'd1;
    step();
    chk("byp_nowr_op1", out_if.alu_operand1_o, 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I instruction decode stage of ECAP5-DPROC. Sits between fetch and execute.
- Drives the two read ports of the register file `regs` and builds ALU operands, immediates and control fields.
- Registers all results into a single output slot with a valid/ready handshake.
- Optionally bypasses the same-cycle writeback value around the register file.

Parameters:
- None. XLEN is fixed at 32.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low; sampled on the rising edge of clk_i.
- input_valid_i  in  1  fetch presents an instruction.
- input_ready_o  out  1  decode accepts this cycle.
- instr_i  in  32  instruction word.
- pc_i  in  32  address of instr_i.
- flush_i  in  1  execute redirect; discard the slot and any incoming instruction.
- raddr1_o  out  5  regfile read address 1 = instr_i[19:15].
- rdata1_i  in  32  regfile read data 1 (combinational).
- raddr2_o  out  5  regfile read address 2 = instr_i[24:20].
- rdata2_i  in  32  regfile read data 2 (combinational).
- wb_write_i  in  1  writeback write enable (same signals as the regfile write port).
- wb_addr_i  in  5  writeback address.
- wb_data_i  in  32  writeback data.
- output_valid_o  out  1  slot holds a decoded instruction.
- output_ready_i  in  1  execute consumes the slot.
- pc_o  out  32  registered pc.
- alu_operand1_o  out  32  first ALU operand.
- alu_operand2_o  out  32  second ALU operand.
- alu_op_o  out  3  funct3-style ALU op; 000 = ADD.
- alu_alt_o  out  1  SUB / SRA select.
- rs1_value_o  out  32  rs1 value (JALR base).
- rs2_value_o  out  32  rs2 value (branch compare, store data).
- branch_type_o  out  2  00 none, 01 JAL, 10 JALR, 11 conditional.
- branch_cond_o  out  3  funct3 of a conditional branch.
- branch_offset_o  out  32  sign-extended J/I/B immediate.
- mem_read_o  out  1  load.
- mem_write_o  out  1  store.
- mem_size_o  out  3  funct3 of the load/store.
- reg_write_o  out  1  instruction writes rd.
- reg_addr_o  out  5  rd; forced to 0 when reg_write_o = 0.
- illegal_o  out  1  unknown opcode.

Behaviour:
- Reset (rst_i = 0 at a clock edge): every registered output is 0, including output_valid_o. input_ready_o is 1 while output_valid_o = 0.
- Read addresses: raddr1_o and raddr2_o are combinational from instr_i, independent of input_valid_i.
- Ready: input_ready_o = ~output_valid_o | output_ready_i (combinational).
- Accept: input_valid_i & input_ready_o & ~flush_i. On the next edge all fields are loaded and output_valid_o is set. Latency is 1 cycle; throughput is 1 instruction per cycle.
- No accept, output_ready_i = 1: output_valid_o clears.
- Stall (output_valid_o = 1, output_ready_i = 0): all outputs hold their values.
- flush_i = 1: output_valid_o clears on the next edge. The incoming instruction is dropped even if input_valid_i = 1; flush takes priority. Data fields may keep stale values.
- Immediates follow RV32I I/S/B/U/J formats, sign-extended from instr_i[31].
- Decode per opcode:
  - LUI (0110111): op1 = 0, op2 = U-imm, ADD, reg_write.
  - AUIPC (0010111): op1 = pc, op2 = U-imm, ADD, reg_write.
  - JAL (1101111): op1 = pc, op2 = 4, ADD, reg_write, branch_type 01, offset = J-imm.
  - JALR (1100111): same as JAL, but branch_type 10 and offset = I-imm.
  - BRANCH (1100011): op1 = rs1, op2 = rs2, branch_type 11, branch_cond = funct3, offset = B-imm, reg_write 0.
  - LOAD (0000011): op1 = rs1, op2 = I-imm, ADD, mem_read, mem_size = funct3, reg_write.
  - STORE (0100011): op1 = rs1, op2 = S-imm, ADD, mem_write, mem_size = funct3, reg_write 0.
  - OP-IMM (0010011): op1 = rs1, op2 = I-imm, alu_op = funct3; alu_alt = instr[30] only when funct3 = 101, else 0.
  - OP (0110011): op1 = rs1, op2 = rs2, alu_op = funct3, alu_alt = instr[30].
  - Any other opcode: illegal_o = 1. reg_write, mem_read, mem_write are 0 and branch_type is 00. The slot is still valid so execute can trap.
- rd = 0: reg_write_o follows the table above; the register file ignores writes to address 0.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: when wb_write_i = 1, wb_addr_i != 0 and wb_addr_i equals raddr1_o, the rs1 value is taken from wb_data_i instead of rdata1_i. Port 2 (raddr2_o) is bypassed the same way. Bypassed values feed both the operands and rs1_value_o / rs2_value_o.
- Undefined: rdata1_i and rdata2_i are used as-is, and the wb_* inputs are unused. The pipeline control must then stall across the writeback-to-read hazard.

Test Plan:
- Reset: rst_i = 0 for 2 cycles, input_valid_i = 1 → output_valid_o = 0, all outputs 0, input_ready_o = 1.
- Decode: ADDI x5, x1, -3 with rdata1 = 10 → next cycle op1 = 10, op2 = 0xFFFFFFFD, alu_op = 000, reg_write = 1, reg_addr = 5. BEQ with offset -8 → branch_type 11, cond 000, offset 0xFFFFFFF8, reg_write 0.
- Stall: output_ready_i = 0 for 3 cycles with a new instruction pending → outputs hold, input_ready_o = 0. Raise output_ready_i → the pending instruction loads on the next edge.
- Flush: flush_i = 1 with input_valid_i = 1 and a valid slot → output_valid_o = 0 next cycle, instruction not accepted.
- Illegal: opcode 1111111 → illegal_o = 1, reg_write = 0, mem_write = 0, output_valid_o = 1.
- Bypass (with DECODE_BYPASS_EN): wb_write = 1, wb_addr = 1, wb_data = 0x55 while ADD reads x1 with rdata1 = 0 → op1 = 0x55. With wb_addr = 0 → op1 = rdata1_i.
